// File: rtl/puf_pkg.sv
// Shared definitions for the arbiter-PUF challenge sequencer: FSM encoding,
// LFSR defaults and the legal parameter ranges.
package puf_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_FIRE,
    S_SAMPLE,
    S_DECIDE,
    S_DONE
  } state_t;

  localparam logic [31:0] LFSR_TAPS_DEF = 32'h80200003;
  // An all-zero Galois LFSR never leaves zero, so a zero seed is replaced.
  localparam logic [31:0] SEED_ZERO_SUB = 32'h00000001;

  localparam int RESP_BITS_MIN  = 1;
  localparam int RESP_BITS_MAX  = 32;
  localparam int VOTES_MIN      = 1;
  localparam int VOTES_MAX      = 15;
  localparam int REST_CYC_MIN   = 1;
  localparam int SETTLE_CYC_MIN = 1;
  localparam logic [5:0] UNSTABLE_MAX = 6'd63;

endpackage

// File: rtl/puf_lfsr32.sv
// One Galois step of the 32-bit challenge LFSR (right shift, taps folded in
// when the outgoing bit is 1).
module puf_lfsr32
  import puf_pkg::*;
#(
  parameter logic [31:0] TAPS = LFSR_TAPS_DEF
) (
  input  logic [31:0] cur,
  output logic [31:0] nxt
);

  always_comb begin
    nxt = cur >> 1;
    if (cur[0]) nxt = nxt ^ TAPS;
  end

endmodule

// File: rtl/puf_chal_seq.sv
// Challenge sequencer for one arbiter PUF: applies each challenge, launches
// VOTES times, majority-votes the arbiter output and counts unstable bits.
module puf_chal_seq
  import puf_pkg::*;
#(
  parameter int          RESP_BITS  = 32,
  parameter int          VOTES      = 7,
  parameter int          REST_CYC   = 4,
  parameter int          SETTLE_CYC = 8,
  parameter logic [31:0] LFSR_TAPS  = LFSR_TAPS_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [31:0]          seed,
  input  logic                 q,
  output logic [31:0]          sel,
  output logic                 ce,
  output logic                 busy,
  output logic                 done,
  output logic [RESP_BITS-1:0] resp,
  output logic [5:0]           unstable
);

  localparam int TMAX = (REST_CYC > SETTLE_CYC) ? REST_CYC : SETTLE_CYC;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0] REST_LAST   = TW'(REST_CYC - 1);
  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYC - 1);
  localparam logic [3:0]    VOTES_L     = 4'(VOTES);
  localparam logic [3:0]    VOTES_HALF  = 4'(VOTES / 2);
  localparam logic [5:0]    BIT_LAST    = 6'(RESP_BITS - 1);

  if (RESP_BITS < RESP_BITS_MIN || RESP_BITS > RESP_BITS_MAX ||
      VOTES < VOTES_MIN || VOTES > VOTES_MAX || (VOTES % 2) == 0 ||
      REST_CYC < REST_CYC_MIN || SETTLE_CYC < SETTLE_CYC_MIN) begin : g_bad_param
    $error("puf_chal_seq: parameter out of range");
  end

  state_t                state_q, state_d;
  logic [31:0]           sel_q, sel_d;
  logic                  ce_q, ce_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [RESP_BITS-1:0]  resp_q, resp_d;
  logic [5:0]            unstable_q, unstable_d;
  logic [5:0]            bit_idx_q, bit_idx_d;
  logic [3:0]            vote_cnt_q, vote_cnt_d;
  logic [3:0]            ones_cnt_q, ones_cnt_d;
  logic [TW-1:0]         tmr_q, tmr_d;
  logic [31:0]           sel_step;

  puf_lfsr32 #(.TAPS(LFSR_TAPS)) u_lfsr (
    .cur (sel_q),
    .nxt (sel_step)
  );

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    busy_d     = busy_q;
    resp_d     = resp_q;
    unstable_d = unstable_q;
    bit_idx_d  = bit_idx_q;
    vote_cnt_d = vote_cnt_q;
    ones_cnt_d = ones_cnt_q;
    tmr_d      = tmr_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          sel_d      = (seed == 32'h0) ? SEED_ZERO_SUB : seed;
          resp_d     = '0;
          unstable_d = '0;
          bit_idx_d  = '0;
          vote_cnt_d = '0;
          ones_cnt_d = '0;
          tmr_d      = '0;
          busy_d     = 1'b1;
          state_d    = S_APPLY;
        end
      end
      S_APPLY: begin
        if (tmr_q == REST_LAST) begin
          tmr_d   = '0;
          state_d = S_FIRE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_FIRE: begin
        if (tmr_q == SETTLE_LAST) begin
          tmr_d   = '0;
          state_d = S_SAMPLE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_SAMPLE: begin
        ones_cnt_d = ones_cnt_q + {3'b000, q};
        vote_cnt_d = vote_cnt_q + 4'd1;
        state_d    = (vote_cnt_d == VOTES_L) ? S_DECIDE : S_APPLY;
      end
      S_DECIDE: begin
        for (int i = 0; i < RESP_BITS; i++) begin
          if (bit_idx_q == 6'(i)) resp_d[i] = (ones_cnt_q > VOTES_HALF);
        end
        if (ones_cnt_q != 4'd0 && ones_cnt_q != VOTES_L &&
            unstable_q != UNSTABLE_MAX) begin
          unstable_d = unstable_q + 6'd1;
        end
        sel_d      = sel_step;
        vote_cnt_d = '0;
        ones_cnt_d = '0;
        bit_idx_d  = bit_idx_q + 6'd1;
        state_d    = (bit_idx_q == BIT_LAST) ? S_DONE : S_APPLY;
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    // Abort discards whatever this cycle would have committed.
    if (abort && state_q != S_IDLE) begin
      state_d    = S_IDLE;
      busy_d     = 1'b0;
      sel_d      = sel_q;
      resp_d     = resp_q;
      unstable_d = unstable_q;
      bit_idx_d  = bit_idx_q;
      vote_cnt_d = vote_cnt_q;
      ones_cnt_d = ones_cnt_q;
      tmr_d      = '0;
    end

    ce_d   = (state_d == S_FIRE) || (state_d == S_SAMPLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      sel_q      <= '0;
      ce_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      resp_q     <= '0;
      unstable_q <= '0;
      bit_idx_q  <= '0;
      vote_cnt_q <= '0;
      ones_cnt_q <= '0;
      tmr_q      <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      ce_q       <= ce_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      resp_q     <= resp_d;
      unstable_q <= unstable_d;
      bit_idx_q  <= bit_idx_d;
      vote_cnt_q <= vote_cnt_d;
      ones_cnt_q <= ones_cnt_d;
      tmr_q      <= tmr_d;
    end
  end

  assign sel      = sel_q;
  assign ce       = ce_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign resp     = resp_q;
  assign unstable = unstable_q;

endmodule

// File: tb/tb_puf_chal_seq.sv
// Bench for puf_chal_seq in a small configuration (4 bits, 3 votes, rest 2,
// settle 3): vector table plus abort, held-start and mid-run reset sequences.
module tb_puf_chal_seq;

  localparam int RB = 4;
  localparam int V  = 3;
  localparam int RC = 2;
  localparam int SC = 3;
  localparam int VB = RC + SC + 1;      // cycles per vote
  localparam int BB = V * VB + 1;       // cycles per response bit
  localparam int DONE_IDX = RB * BB;    // done is high after this many edges past start

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [31:0]   seed = 32'h0;
  logic          q = 1'b0;
  logic [31:0]   sel;
  logic          ce;
  logic          busy;
  logic          done;
  logic [RB-1:0] resp;
  logic [5:0]    unstable;

  puf_chal_seq #(
    .RESP_BITS  (RB),
    .VOTES      (V),
    .REST_CYC   (RC),
    .SETTLE_CYC (SC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .seed     (seed),
    .q        (q),
    .sel      (sel),
    .ce       (ce),
    .busy     (busy),
    .done     (done),
    .resp     (resp),
    .unstable (unstable)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [9:0] exp_q[$];

  typedef struct {
    logic [31:0] seed;
    logic [11:0] pat;    // pat[bit*V + vote] is q for that evaluation
    logic [3:0]  resp;
    logic [5:0]  uns;
  } vec_t;

  vec_t vecs[5];
  logic [31:0] sel_seen[RB];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] lfsr_ref(input logic [31:0] s);
    logic [31:0] r;
    r = {1'b0, s[31:1]};
    if (s[0]) r = r ^ 32'h80200003;
    return r;
  endfunction

  function automatic logic pat_q(input logic [11:0] pat, input int n);
    int b, r;
    b = n / BB;
    r = n % BB;
    if (b < RB && r < BB - 1) return pat[b * V + r / VB];
    return 1'b0;
  endfunction

  // Full run: start at the next edge, follow sel/ce/busy/done cycle by cycle.
  task automatic run_vec(input int vi, input bit hold);
    logic [31:0] chal;
    logic [9:0]  e;
    int b, r;
    @(negedge clk);
    seed  = vecs[vi].seed;
    start = 1'b1;
    q     = 1'b0;
    exp_q.push_back({vecs[vi].resp, vecs[vi].uns});
    chal = (vecs[vi].seed == 32'h0) ? 32'h1 : vecs[vi].seed;
    for (int n = 0; n <= DONE_IDX; n++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      else seed = ~seed;
      if (n < DONE_IDX) begin
        b = n / BB;
        r = n % BB;
        if (r == 0 && b > 0) chal = lfsr_ref(chal);
        if (r == 0) sel_seen[b] = sel;
        chk("sel", sel, chal);
        chk("ce", {31'b0, ce}, {31'b0, (r < BB - 1) && ((r % VB) >= RC)});
        chk("busy", {31'b0, busy}, 32'h1);
        chk("done_early", {31'b0, done}, 32'h0);
      end else begin
        chk("done_pulse", {31'b0, done}, 32'h1);
        chk("sel_done", sel, lfsr_ref(chal));
        start = 1'b0;
      end
      q = pat_q(vecs[vi].pat, n);
    end
    @(negedge clk);
    chk("done_clear", {31'b0, done}, 32'h0);
    chk("busy_idle", {31'b0, busy}, 32'h0);
    chk("ce_idle", {31'b0, ce}, 32'h0);
    e = exp_q.pop_front();
    chk("resp_uns", {22'b0, resp, unstable}, {22'b0, e});
  endtask

  task automatic abort_seq();
    logic [31:0] s0;
    logic [9:0]  e;
    logic        saw_done;
    s0 = 32'hA5A50F0F;
    @(negedge clk);
    seed  = s0;
    start = 1'b1;
    q     = 1'b1;
    exp_q.push_back({4'b0001, 6'd0});
    for (int n = 0; n <= 30; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (n == 29) abort = 1'b1;
      if (n == 30) begin
        abort = 1'b0;
        chk("abort_busy", {31'b0, busy}, 32'h0);
        chk("abort_ce", {31'b0, ce}, 32'h0);
        e = exp_q.pop_front();
        chk("abort_partial", {22'b0, resp, unstable}, {22'b0, e});
        chk("abort_sel", sel, lfsr_ref(s0));
      end
    end
    saw_done = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    chk("abort_no_done", {31'b0, saw_done}, 32'h0);
    chk("abort_sel_hold", sel, lfsr_ref(s0));
    q = 1'b0;
  endtask

  task automatic reset_seq();
    @(negedge clk);
    seed  = 32'h0BADF00D;
    start = 1'b1;
    q     = 1'b1;
    for (int n = 0; n <= 22; n++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("pre_rst_ce", {31'b0, ce}, 32'h1);
    chk("pre_rst_resp", {28'b0, resp}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst_ce", {31'b0, ce}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_sel", sel, 32'h0);
    chk("rst_resp_uns", {22'b0, resp, unstable}, 32'h0);
    chk("rst_done", {31'b0, done}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    q = 1'b0;
  endtask

  initial begin
    vecs[0] = '{seed: 32'h00000001, pat: 12'hFFF, resp: 4'hF,    uns: 6'd0};
    vecs[1] = '{seed: 32'hDEADBEEF, pat: 12'hE13, resp: 4'b1001, uns: 6'd2};
    vecs[2] = '{seed: 32'h00000000, pat: 12'h000, resp: 4'h0,    uns: 6'd0};
    vecs[3] = '{seed: 32'h12345678, pat: 12'hB6D, resp: 4'hF,    uns: 6'd4};
    vecs[4] = '{seed: 32'hCAFEF00D, pat: 12'h39C, resp: 4'b0110, uns: 6'd4};

    repeat (2) @(negedge clk);
    chk("reset_outs", {sel[3:0], ce, busy, done, resp, unstable},
        32'h0);
    chk("reset_sel", sel, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", {31'b0, busy}, 32'h0);

    run_vec(0, 1'b0);
    chk("sel_seq0", sel_seen[0], 32'h00000001);
    chk("sel_seq1", sel_seen[1], 32'h80200003);
    chk("sel_seq2", sel_seen[2], 32'hC0300002);
    chk("sel_seq3", sel_seen[3], 32'h60180001);

    run_vec(1, 1'b0);
    run_vec(2, 1'b0);
    abort_seq();
    run_vec(3, 1'b0);
    run_vec(4, 1'b1);
    reset_seq();
    run_vec(1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
